ins_mem_loader: RTL
===================

INS_MEM_LOADER -- requirements
Module: ins_mem_loader

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the word-count input and of the internal remaining-word counter.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port START, input, 1: one-cycle load request; sampled only in IDLE.
REQ-005 SHALL have port BASE_ADR, input, 32: byte address of the first word; sampled with START.
REQ-006 SHALL have port WORD_COUNT, input, CNT_W: number of 32-bit words to load; sampled with START.
REQ-007 SHALL have port BYTE_IN, input, 8: incoming program byte.
REQ-008 SHALL have port BYTE_VALID, input, 1: BYTE_IN is valid this cycle.
REQ-009 SHALL have port BYTE_READY, output, 1: loader accepts BYTE_IN this cycle.
REQ-010 SHALL have port WR_EN, output, 1: instruction-memory write request.
REQ-011 SHALL have port WR_ADR, output, 32: write byte address.
REQ-012 SHALL have port WR_DATA, output, 32: assembled instruction word.
REQ-013 SHALL have port WR_ACK, input, 1: memory has accepted the write this cycle.
REQ-014 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-015 SHALL have port DONE, output, 1: one-cycle pulse when the load completes.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE and FINISH.
REQ-017 IDLE with START=1 SHALL latch BASE_ADR and WORD_COUNT, clear the byte index, and go to FINISH if WORD_COUNT=0, otherwise to COLLECT.
REQ-018 A byte SHALL be transferred only in a cycle with BYTE_VALID=1 and BYTE_READY=1; BYTE_READY SHALL be 1 only in COLLECT.
REQ-019 SHALL pack bytes big-endian: the first byte goes to WR_DATA[31:24] and the fourth to WR_DATA[7:0].
REQ-020 After the fourth accepted byte, SHALL go to WRITE in the next cycle with WR_EN=1 (latency from the 4th byte to WR_EN is 1 cycle).
REQ-021 In WRITE, WR_EN, WR_ADR and WR_DATA SHALL hold stable until WR_ACK=1 is sampled.
REQ-022 On WR_ACK, SHALL add 4 to the address (modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000), decrement the remaining count, and go to COLLECT if the count is nonzero, else to FINISH.
REQ-023 FINISH SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-024 START outside IDLE SHALL be ignored.
REQ-025 WR_ACK outside WRITE SHALL be ignored.
REQ-026 BYTE_VALID while BYTE_READY=0 SHALL NOT consume the byte.
REQ-027 WR_ACK in the same cycle WR_EN first rises SHALL complete the write (minimum 1 cycle in WRITE).
REQ-028 WR_ADR SHALL equal BASE_ADR + 4*k for the k-th word (k from 0).

Reset
REQ-029 RST=1 SHALL immediately force IDLE, BYTE_READY=0, WR_EN=0, WR_ADR=0, WR_DATA=0, BUSY=0, DONE=0, byte index=0, count=0.
REQ-030 RST mid-load SHALL abandon the partial word without issuing a write; the next START SHALL begin a clean load.

Configuration
REQ-031 With macro LOADER_CHECKSUM_EN defined, SHALL add output CHKSUM (32): wrapping 32-bit sum of all acknowledged WR_DATA words, cleared by reset and by an accepted START, and stable from DONE until the next START.
REQ-032 Without LOADER_CHECKSUM_EN, the CHKSUM port and its adder SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 State encoding enum (IDLE, COLLECT, WRITE, FINISH) and constant WORD_BYTES=4 SHALL reside in the shared package ins_mem_pkg.
REQ-034 Byte packing SHALL be a sub-module ins_word_packer (shift register, byte index, word-full flag); the FSM and address/count logic SHALL stay in ins_mem_loader.

Verification
REQ-035 START with BASE_ADR=0x00400000, WORD_COUNT=2, bytes 12 34 56 78 9A BC DE F0, WR_ACK immediate -> writes 0x12345678@0x00400000 and 0x9ABCDEF0@0x00400004, then a single DONE pulse.
REQ-036 START with WORD_COUNT=0 -> DONE pulse 1 cycle later, WR_EN never asserted.
REQ-037 WR_ACK delayed 5 cycles -> WR_EN, WR_ADR and WR_DATA stable for all 5 cycles, BYTE_READY=0 throughout.
REQ-038 BASE_ADR=0xFFFFFFFC, WORD_COUNT=2 -> second WR_ADR=0x00000000.
REQ-039 RST asserted after 2 bytes of a word -> no write, all outputs at reset values; a new START with 4 bytes writes the correct word.
REQ-040 With LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> CHKSUM=0x00000001 at DONE.

Source files
------------

// File: rtl/ins_mem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and word geometry.
// Optional build macro used by the loader: LOADER_CHECKSUM_EN.
package ins_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = WORD_BYTES * 8;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/ins_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB-first, tracks the byte index and
// flags a complete word until the loader drains it.
module ins_word_packer
  import ins_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic              drain_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o,
  output logic              last_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic              full_q, full_d;

  // High in the cycle the final byte of a word is being accepted.
  assign last_o = shift_i && (idx_q == IDX_W'(WORD_BYTES - 1));

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (clear_i) begin
      idx_d  = '0;
      full_d = 1'b0;
    end else if (shift_i) begin
      word_d = {word_q[WORD_W-9:0], byte_i};
      idx_d  = idx_q + IDX_W'(1);
      full_d = last_o;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign word_o = word_q;
  assign full_o = full_q;

endmodule

// File: rtl/ins_mem_loader.sv
// Streams program bytes into instruction memory as big-endian 32-bit words at consecutive addresses.
// Define LOADER_CHECKSUM_EN to add the CHKSUM output (wrapping sum of acknowledged words).
module ins_mem_loader
  import ins_mem_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      BASE_ADR,
  input  logic [CNT_W-1:0] WORD_COUNT,
  input  logic [7:0]       BYTE_IN,
  input  logic             BYTE_VALID,
  output logic             BYTE_READY,
  output logic             WR_EN,
  output logic [31:0]      WR_ADR,
  output logic [31:0]      WR_DATA,
  input  logic             WR_ACK,
  output logic             BUSY,
  output logic             DONE
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      CHKSUM
`endif
);

  state_t           state_q, state_d;
  logic [31:0]      adr_q,   adr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic              start_acc;
  logic              ack_acc;
  logic              byte_take;
  logic [WORD_W-1:0] word;
  logic              word_full;
  logic              word_last;

  assign byte_take = BYTE_READY && BYTE_VALID;

  ins_word_packer u_packer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (start_acc),
    .shift_i (byte_take),
    .drain_i (ack_acc),
    .byte_i  (BYTE_IN),
    .word_o  (word),
    .full_o  (word_full),
    .last_o  (word_last)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    start_acc  = 1'b0;
    ack_acc    = 1'b0;
    BYTE_READY = 1'b0;
    DONE       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          adr_d     = BASE_ADR;
          cnt_d     = WORD_COUNT;
          state_d   = (WORD_COUNT == '0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        BYTE_READY = 1'b1;
        if (word_last) state_d = WRITE;
      end
      WRITE: begin
        if (WR_ACK) begin
          ack_acc = 1'b1;
          adr_d   = adr_q + 32'd4;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? FINISH : COLLECT;
        end
      end
      FINISH: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      adr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
    end
  end

  // The full flag is always set on entry to WRITE; gating keeps WR_EN tied to a held word.
  assign WR_EN   = (state_q == WRITE) && word_full;
  assign WR_ADR  = adr_q;
  assign WR_DATA = word;
  assign BUSY    = (state_q != IDLE);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chk_q <= '0;
    end else if (start_acc) begin
      chk_q <= '0;
    end else if (ack_acc) begin
      chk_q <= chk_q + word;
    end
  end

  assign CHKSUM = chk_q;
`endif

endmodule
